// File: rtl/gate_pkg.sv
// Shared definitions for the basic-gate self-test slice.
//   - op codes driven on the gate unit's op-select mux
//   - sequencer FSM state encoding
//   - gate_golden(): reference truth table for every op code
package gate_pkg;

    localparam int NUM_OPS = 5;

    localparam logic [2:0] OP_NAND = 3'd0;
    localparam logic [2:0] OP_NOT  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StCheck,
        StAdvance,
        StDone
    } state_e;

    // Expected gate output; NOT ignores b. Unused codes read as 0.
    function automatic logic gate_golden(input logic [2:0] op, input logic a, input logic b);
        case (op)
            OP_NAND: return ~(a & b);
            OP_NOT:  return ~a;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/gate_unit.sv
// Shared basic-gate unit: five gates behind one op-select mux.
//   a, b : gate inputs
//   op   : op select (0 NAND, 1 NOT, 2 AND, 3 OR, 4 XOR)
//   y    : selected gate output; unused codes drive 0
module gate_unit
    import gate_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [2:0] op,
    output logic       y
);

    logic y_nand, y_not, y_and, y_or, y_xor;

    assign y_nand = ~(a & b);
    assign y_not  = ~a;
    assign y_and  = a & b;
    assign y_or   = a | b;
    assign y_xor  = a ^ b;

    always_comb begin
        y = 1'b0;
        case (op)
            OP_NAND: y = y_nand;
            OP_NOT:  y = y_not;
            OP_AND:  y = y_and;
            OP_OR:   y = y_or;
            OP_XOR:  y = y_xor;
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/next_op_sel.sv
// Combinational priority encoder picking the next enabled gate op.
//   mask    : enabled ops, bit i enables op i
//   cur     : current op; -1 selects the lowest enabled op
//   next_op : lowest enabled op strictly above cur (0 when none)
//   none    : no enabled op exists above cur
module next_op_sel
    import gate_pkg::*;
(
    input  logic [NUM_OPS-1:0] mask,
    input  logic signed [3:0]  cur,
    output logic [2:0]         next_op,
    output logic               none
);

    // Scan downward so the lowest qualifying op is the last one written.
    always_comb begin
        next_op = 3'd0;
        none    = 1'b1;
        for (int i = NUM_OPS - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                next_op = 3'(i);
                none    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer for the shared basic-gate unit.
// Walks every enabled op through {a,b} = 00..11, samples y after a settle time,
// compares against gate_golden(), counts mismatches and latches the first failure.
// Ports:
//   clock, reset         : single clock, synchronous active-high reset
//   start, op_mask       : sweep request (accepted in IDLE only) and op enables
//   y                    : gate unit output
//   a, b, op             : registered vector driven to the gate unit
//   busy, done, pass     : handshake; done is a one-cycle pulse, pass valid from done
//   err_count, vec_count : mismatches / vectors checked in the current or last sweep
//   fail_valid, fail_op, fail_ab : first failing vector
module gate_sweep_ctrl
    import gate_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] op_mask,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic [2:0] op,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [4:0] vec_count,
    output logic       fail_valid,
    output logic [2:0] fail_op,
    output logic [1:0] fail_ab
);

    // Settle counter counts down to zero, so SETTLE lasts SETTLE_CYCLES cycles.
    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [4:0] mask_q, mask_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic [2:0] op_q, op_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] err_q, err_d;
    logic [4:0] vec_q, vec_d;
    logic       fvalid_q, fvalid_d;
    logic [2:0] fop_q, fop_d;
    logic [1:0] fab_q, fab_d;
    logic       pass_q, pass_d;

    // One encoder serves both the first-op pick (IDLE, live mask, cur = -1)
    // and the advance to the next op (captured mask, cur = op_q).
    logic [4:0]        sel_mask;
    logic signed [3:0] sel_cur;
    logic [2:0]        sel_op;
    logic              sel_none;

    assign sel_mask = (state_q == StIdle) ? op_mask : mask_q;
    assign sel_cur  = (state_q == StIdle) ? -4'sd1 : $signed({1'b0, op_q});

    next_op_sel u_next_op_sel (
        .mask    (sel_mask),
        .cur     (sel_cur),
        .next_op (sel_op),
        .none    (sel_none)
    );

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        vec_d    = vec_q;
        fvalid_d = fvalid_q;
        fop_d    = fop_q;
        fab_d    = fab_q;
        pass_d   = pass_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    mask_d   = op_mask;
                    err_d    = 5'd0;
                    vec_d    = 5'd0;
                    fvalid_d = 1'b0;
                    fop_d    = 3'd0;
                    fab_d    = 2'd0;
                    pass_d   = 1'b0;
                    if (!sel_none) begin
                        op_d    = sel_op;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                        cnt_d   = SettleLoad;
                        state_d = StSettle;
                    end else begin
                        // Nothing to test: an empty sweep trivially passes.
                        pass_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end

            StSettle: begin
                if (cnt_q == 4'd0) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            StCheck: begin
                vec_d = vec_q + 5'd1;
                if (y != gate_golden(op_q, a_q, b_q)) begin
                    err_d = err_q + 5'd1;
                    if (!fvalid_q) begin
                        fvalid_d = 1'b1;
                        fop_d    = op_q;
                        fab_d    = {a_q, b_q};
                    end
                end
                state_d = StAdvance;
            end

            StAdvance: begin
                cnt_d = SettleLoad;
                if ({a_q, b_q} != 2'b11) begin
                    {a_d, b_d} = {a_q, b_q} + 2'd1;
                    state_d    = StSettle;
                end else if (!sel_none) begin
                    op_d    = sel_op;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    state_d = StSettle;
                end else begin
                    // err_count is final here, so pass is ready as done rises.
                    pass_d  = (err_q == 5'd0);
                    state_d = StDone;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            mask_q   <= 5'd0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            op_q     <= 3'd0;
            cnt_q    <= 4'd0;
            err_q    <= 5'd0;
            vec_q    <= 5'd0;
            fvalid_q <= 1'b0;
            fop_q    <= 3'd0;
            fab_q    <= 2'd0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            vec_q    <= vec_d;
            fvalid_q <= fvalid_d;
            fop_q    <= fop_d;
            fab_q    <= fab_d;
            pass_q   <= pass_d;
        end
    end

    assign a          = a_q;
    assign b          = b_q;
    assign op         = op_q;
    assign busy       = (state_q == StSettle) || (state_q == StCheck) || (state_q == StAdvance);
    assign done       = (state_q == StDone);
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign vec_count  = vec_q;
    assign fail_valid = fvalid_q;
    assign fail_op    = fop_q;
    assign fail_ab    = fab_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl driving a real gate_unit with optional
// fault injection on y. Expected results come from a sweep model built on gate_golden.
module tb_gate_sweep_ctrl;
    import gate_pkg::*;

    localparam int unsigned S = 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [4:0] op_mask = 5'd0;
    logic       y, gate_y;
    logic       a, b, busy, done, pass, fail_valid;
    logic [2:0] op, fail_op;
    logic [1:0] fail_ab;
    logic [4:0] err_count, vec_count;

    int tests = 0;
    int fails = 0;
    int fault_mode = 0;  // 0 none, 1 XOR inverted at ab=01, 2 NAND stuck-at-0

    always #5 clock = ~clock;

    // Fault definition: returns 1 where the faulty unit's y differs from a good one.
    function automatic logic fault_flip(input int mode, input logic [2:0] o, input logic [1:0] ab);
        if (mode == 1) return (o == OP_XOR) && (ab == 2'b01);
        if (mode == 2) return (o == OP_NAND) && gate_golden(o, ab[1], ab[0]);
        return 1'b0;
    endfunction

    gate_unit u_gate (
        .a  (a),
        .b  (b),
        .op (op),
        .y  (gate_y)
    );

    assign y = gate_y ^ fault_flip(fault_mode, op, {a, b});

    gate_sweep_ctrl #(
        .SETTLE_CYCLES (S)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .op_mask    (op_mask),
        .y          (y),
        .a          (a),
        .b          (b),
        .op         (op),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .vec_count  (vec_count),
        .fail_valid (fail_valid),
        .fail_op    (fail_op),
        .fail_ab    (fail_ab)
    );

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        op_mask = 5'h1f;
        repeat (3) @(posedge clock);
        #1;
        tests++;
        if ({a, b, op, busy, done, pass, err_count, vec_count, fail_valid, fail_op, fail_ab}
            !== 24'd0) begin
            fails++;
            $display("FAIL reset_values: got %h expected 0",
                     {a, b, op, busy, done, pass, err_count, vec_count, fail_valid, fail_op,
                      fail_ab});
        end
        start = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    // Runs one sweep and compares everything against the model.
    // inject >= 0 raises start with a different mask mid-sweep (must be ignored).
    task automatic test_sweep(input string name, input logic [4:0] mask, input int mode,
                              input int inject);
        logic [4:0] exp_q[$];
        logic [4:0] obs_q[$];
        int         exp_err, exp_vec, exp_lat, obs_lat;
        logic       exp_fv, gold, busy_at_k, busy_at_done, seq_ok, pass_seen;
        logic [2:0] exp_fop;
        logic [1:0] exp_fab;

        exp_err = 0;
        exp_vec = 0;
        exp_fv  = 1'b0;
        exp_fop = 3'd0;
        exp_fab = 2'd0;
        for (int o = 0; o < NUM_OPS; o++) begin
            if (mask[o]) begin
                for (int ab = 0; ab < 4; ab++) begin
                    exp_q.push_back({3'(o), 2'(ab)});
                    exp_vec++;
                    gold = gate_golden(3'(o), ab[1], ab[0]);
                    if ((gold ^ fault_flip(mode, 3'(o), 2'(ab))) != gold) begin
                        exp_err++;
                        if (!exp_fv) begin
                            exp_fv  = 1'b1;
                            exp_fop = 3'(o);
                            exp_fab = 2'(ab);
                        end
                    end
                end
            end
        end
        exp_lat = exp_vec * (int'(S) + 2) + 1;

        fault_mode = mode;
        @(negedge clock);
        op_mask = mask;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start        = 1'b0;
        op_mask      = 5'($urandom);
        busy_at_k    = busy;
        busy_at_done = 1'b0;
        obs_lat      = -1;
        for (int j = 0; j < 400; j++) begin
            if (busy && (obs_q.size() == 0 || {op, a, b} != obs_q[$])) obs_q.push_back({op, a, b});
            if (done) begin
                obs_lat      = j + 1;
                busy_at_done = busy;
                break;
            end
            if (j == inject) begin
                start   = 1'b1;
                op_mask = ~mask;
            end else if (j == inject + 1) begin
                start = 1'b0;
            end
            @(posedge clock);
            #1;
        end
        start = 1'b0;
        pass_seen = pass;

        tests++;
        if (obs_lat != exp_lat) begin
            fails++;
            $display("FAIL %s done_latency: got %0d expected %0d (-1 = timeout)", name, obs_lat,
                     exp_lat);
        end
        tests++;
        if (busy_at_k !== (exp_vec != 0)) begin
            fails++;
            $display("FAIL %s busy_after_start: got %b expected %b", name, busy_at_k,
                     exp_vec != 0);
        end
        tests++;
        if (busy_at_done !== 1'b0) begin
            fails++;
            $display("FAIL %s busy_during_done: got %b expected 0", name, busy_at_done);
        end
        tests++;
        if (pass !== (exp_err == 0)) begin
            fails++;
            $display("FAIL %s pass: got %b expected %b", name, pass, exp_err == 0);
        end
        tests++;
        if (err_count !== 5'(exp_err)) begin
            fails++;
            $display("FAIL %s err_count: got %0d expected %0d", name, err_count, exp_err);
        end
        tests++;
        if (vec_count !== 5'(exp_vec)) begin
            fails++;
            $display("FAIL %s vec_count: got %0d expected %0d", name, vec_count, exp_vec);
        end
        tests++;
        if ({fail_valid, fail_op, fail_ab} !== {exp_fv, exp_fop, exp_fab}) begin
            fails++;
            $display("FAIL %s first_fail: got v=%b op=%0d ab=%b expected v=%b op=%0d ab=%b",
                     name, fail_valid, fail_op, fail_ab, exp_fv, exp_fop, exp_fab);
        end
        seq_ok = (obs_q.size() == exp_q.size());
        if (seq_ok) begin
            foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) seq_ok = 1'b0;
        end
        tests++;
        if (!seq_ok) begin
            fails++;
            $display("FAIL %s vector_order: got %0d vectors %p expected %0d vectors %p", name,
                     obs_q.size(), obs_q, exp_q.size(), exp_q);
        end

        @(posedge clock);
        #1;
        tests++;
        if (done !== 1'b0 || pass !== pass_seen) begin
            fails++;
            $display("FAIL %s done_one_cycle: got done=%b pass=%b expected done=0 pass=%b",
                     name, done, pass, pass_seen);
        end
        fault_mode = 0;
    endtask

    task automatic test_random_masks();
        logic [4:0] m;
        int         md;
        for (int i = 0; i < 8; i++) begin
            m  = 5'($urandom_range(1, 31));
            md = int'($urandom_range(0, 2));
            test_sweep($sformatf("random%0d", i), m, md, -1);
        end
    endtask

    task automatic test_mid_reset();
        logic done_seen;
        done_seen = 1'b0;
        @(negedge clock);
        op_mask = 5'h1f;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int j = 0; j < 20; j++) begin
            if (done) done_seen = 1'b1;
            if (j == 19) reset = 1'b1;
            @(posedge clock);
            #1;
        end
        tests++;
        if ({a, b, op, busy, done, pass, err_count, vec_count, fail_valid, fail_op, fail_ab}
            !== 24'd0 || done_seen) begin
            fails++;
            $display("FAIL mid_reset_values: got %h early_done=%b expected 0 and 0",
                     {a, b, op, busy, done, pass, err_count, vec_count, fail_valid, fail_op,
                      fail_ab}, done_seen);
        end
        reset = 1'b0;
        for (int j = 0; j < 70; j++) begin
            if (done || busy) done_seen = 1'b1;
            @(posedge clock);
            #1;
        end
        tests++;
        if (done_seen) begin
            fails++;
            $display("FAIL mid_reset_quiet: got activity after reset expected none");
        end
    endtask

    // start held high: the second sweep is accepted the cycle after done.
    task automatic test_back_to_back();
        logic [4:0] m;
        logic [2:0] low;
        int         got;
        m   = 5'($urandom_range(1, 31));
        low = 3'd0;
        for (int i = NUM_OPS - 1; i >= 0; i--) if (m[i]) low = 3'(i);
        @(negedge clock);
        op_mask = m;
        start   = 1'b1;
        got     = 0;
        for (int j = 0; j < 200 && !got[0]; j++) begin
            @(posedge clock);
            #1;
            if (done) got = 1;
        end
        @(posedge clock);
        #1;
        tests++;
        if (!got[0] || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle_gap: got done_seen=%0d busy=%b done=%b expected 1 0 0", got,
                     busy, done);
        end
        @(posedge clock);
        #1;
        start = 1'b0;
        tests++;
        if ({busy, op, a, b, vec_count} !== {1'b1, low, 2'b00, 5'd0}) begin
            fails++;
            $display("FAIL b2b_restart: got busy=%b op=%0d ab=%b vec=%0d expected 1 %0d 00 0",
                     busy, op, {a, b}, vec_count, low);
        end
        got = 0;
        for (int j = 0; j < 200 && !got[0]; j++) begin
            @(posedge clock);
            #1;
            if (done) got = 1;
        end
        tests++;
        if (!got[0] || vec_count !== 5'(4 * $countones(m)) || pass !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second_sweep: got done_seen=%0d vec=%0d pass=%b expected 1 %0d 1",
                     got, vec_count, pass, 4 * $countones(m));
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        test_reset();
        test_sweep("full_sweep", 5'b11111, 0, -1);
        test_sweep("single_fault", 5'b11111, 1, -1);
        test_sweep("sparse_mask", 5'b10010, 0, -1);
        test_sweep("zero_mask", 5'b00000, 0, -1);
        test_sweep("multi_fault", 5'b11111, 2, -1);
        test_sweep("start_while_busy", 5'b11111, 0, 10);
        test_random_masks();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
